// File: rtl/pip_fir_filter_pkg.sv
// Shared types and constants for the 16-tap pipelined low-pass FIR.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pip_fir_pkg;

    localparam int DATA_W    = 33;
    localparam int COEF_W    = 16;
    localparam int NTAPS     = 16;
    localparam int COEF_FRAC = 15;
    // Full-precision accumulator: product width plus one growth bit per tree level.
    localparam int ACC_W     = DATA_W + COEF_W + $clog2(NTAPS);
    // Delay line, product stage, tree levels, output register.
    localparam int LATENCY   = 3 + $clog2(NTAPS);

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Symmetric Q1.15 low-pass taps; they sum to 32768 (unity DC gain).
    localparam coef_t COEFS [NTAPS] = '{
        -16'sd128,  -16'sd256,  16'sd0,     16'sd768,
         16'sd2048,  16'sd3584, 16'sd4736,  16'sd5632,
         16'sd5632,  16'sd4736, 16'sd3584,  16'sd2048,
         16'sd768,   16'sd0,   -16'sd256,  -16'sd128
    };

    // Bounds of the output sample range, used when saturating.
    localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/pip_fir_filter_if.sv
// Sample bus of the FIR: one input sample and one output sample per clock.
// Latency: n/a (wires only).
// Backpressure: none; every cycle carries a valid sample.
// Signals: x (sample into the filter), y (filtered sample out of the filter).
interface pip_fir_filter_if ();
    import pip_fir_pkg::*;

    sample_t x;
    sample_t y;

    // master: the sample source / sink around the filter.
    modport master (output x, input y);
    // slave: the filter itself.
    modport slave  (input x, output y);
endinterface

// File: rtl/pip_fir_filter_adder_tree.sv
// Pipelined binary reduction of N accumulator-width operands to one sum.
// Latency: log2(N) cycles, one register per tree level.
// Backpressure: none; a new operand set is accepted every cycle.
// Ports: clk, rst_n (async active-low), in_dat[N] operands, sum_dat result.
module pip_fir_adder_tree
    import pip_fir_pkg::*;
#(
    parameter int N = NTAPS
) (
    input  logic clk,
    input  logic rst_n,
    input  acc_t in_dat [N],
    output acc_t sum_dat
);

    localparam int LEVELS = $clog2(N);

    // All tree nodes packed into one array. Level l holds N>>(l+1) partial
    // sums starting at offset N - (N>>l); the last entry is the root.
    acc_t node_d [N-1];
    acc_t node_q [N-1];

    always_comb begin
        for (int k = 0; k < N-1; k++) begin
            node_d[k] = '0;
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < (N >> (l+1)); i++) begin
                if (l == 0) begin
                    node_d[i] = in_dat[2*i] + in_dat[2*i+1];
                end else begin
                    node_d[(N - (N >> l)) + i] =
                        node_q[(N - (N >> (l-1))) + 2*i] +
                        node_q[(N - (N >> (l-1))) + 2*i + 1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N-1; k++) begin
                node_q[k] <= '0;
            end
        end else begin
            node_q <= node_d;
        end
    end

    assign sum_dat = node_q[N-2];

endmodule

// File: rtl/pip_fir_filter.sv
// Fully pipelined 16-tap direct-form FIR low-pass filter, fixed Q1.15 taps.
// Latency: 7 cycles from x capture edge to y update (delay line, products, 4 tree levels, output).
// Backpressure: none; one sample in and one sample out every clock, no stall.
// Ports: clk, reset (async active-low, clears all pipeline state),
//        bus.x signed input sample, bus.y registered signed filtered output.
// Build option: PIP_FIR_SAT_EN clamps the output to the sample range instead of wrapping.
module pip_fir_filter
    import pip_fir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    pip_fir_filter_if.slave   bus
);

    sample_t tap_d  [NTAPS];
    sample_t tap_q  [NTAPS];
    acc_t    prod_d [NTAPS];
    acc_t    prod_q [NTAPS];
    acc_t    tree_sum;
    sample_t y_d;
    sample_t y_q;

    // Delay line: tap 0 holds the newest sample.
    always_comb begin
        tap_d[0] = bus.x;
        for (int k = 1; k < NTAPS; k++) begin
            tap_d[k] = tap_q[k-1];
        end
    end

    // Both operands are sign-extended to the accumulator width before the
    // multiply so the product and everything downstream stays signed.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            prod_d[k] = acc_t'(tap_q[k]) * acc_t'(COEFS[k]);
        end
    end

    pip_fir_adder_tree #(
        .N       (NTAPS)
    ) u_tree (
        .clk     (clk),
        .rst_n   (reset),
        .in_dat  (prod_q),
        .sum_dat (tree_sum)
    );

`ifdef PIP_FIR_SAT_EN
    acc_t shifted;

    always_comb begin
        shifted = tree_sum >>> COEF_FRAC;
        y_d     = sample_t'(shifted);
        if (shifted > acc_t'(SAMPLE_MAX)) begin
            y_d = SAMPLE_MAX;
        end else if (shifted < acc_t'(SAMPLE_MIN)) begin
            y_d = SAMPLE_MIN;
        end
    end
`else
    // Floor shift, then keep the low DATA_W bits (two's-complement wrap).
    always_comb begin
        y_d = sample_t'(tree_sum >>> COEF_FRAC);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                tap_q[k]  <= '0;
                prod_q[k] <= '0;
            end
            y_q <= '0;
        end else begin
            tap_q  <= tap_d;
            prod_q <= prod_d;
            y_q    <= y_d;
        end
    end

    assign bus.y = y_q;

endmodule

// File: tb/tb_pip_fir_filter.sv
module tb_pip_fir_filter;

    localparam int LAT = 7;
    localparam int NT  = 16;

    typedef logic signed [32:0] smp_t;

    typedef struct {
        smp_t x;
        smp_t y;
    } vec_t;

    logic clk;
    logic reset;

    pip_fir_filter_if bus ();

    pip_fir_filter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int coef [NT] = '{-128, -256, 0, 768, 2048, 3584, 4736, 5632,
                      5632, 4736, 3584, 2048, 768, 0, -256, -128};

    longint hist [NT];
    smp_t   sb [$];
    vec_t   vecs [40];
    smp_t   ovf_exp;

    task automatic check(input string name, input smp_t act, input smp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic smp_t model();
        longint acc;
        longint sh;
        acc = 0;
        for (int k = 0; k < NT; k++) begin
            acc += longint'(coef[k]) * hist[k];
        end
        sh = acc >>> 15;
`ifdef PIP_FIR_SAT_EN
        if (sh > 64'sd4294967295) sh = 64'sd4294967295;
        else if (sh < -64'sd4294967296) sh = -64'sd4294967296;
`endif
        return sh[32:0];
    endfunction

    function automatic void clear_model();
        for (int k = 0; k < NT; k++) hist[k] = 0;
        sb.delete();
    endfunction

    // Drive one sample, queue its expected output, advance one clock and
    // compare whatever output is due. Until LAT results are queued the
    // pipeline still holds post-reset zeros.
    task automatic step(input smp_t xv, input smp_t ev, input bit use_model, input string name);
        bus.x = xv;
        for (int k = NT-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = xv;
        sb.push_back(use_model ? model() : ev);
        @(posedge clk);
        #1;
        if (sb.size() >= LAT) check(name, bus.y, sb.pop_front());
        else                  check({name, "_fill"}, bus.y, 33'sd0);
    endtask

    task automatic apply_reset(input int cycles, input smp_t xv);
        reset = 1'b0;
        bus.x = xv;
        #1;
        check("rst_async", bus.y, 33'sd0);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check("rst_hold", bus.y, 33'sd0);
        end
        @(negedge clk);
        reset = 1'b1;
        clear_model();
    endtask

    initial begin
        // Impulse of 32768 reproduces the taps; impulse of -1 gives floor(-c/32768).
        for (int i = 0; i < 20; i++) begin
            vecs[i].x      = (i == 0) ? 33'sd32768 : 33'sd0;
            vecs[i].y      = (i < NT) ? smp_t'(coef[i]) : 33'sd0;
            vecs[20+i].x   = (i == 0) ? -33'sd1 : 33'sd0;
            vecs[20+i].y   = (i < NT && coef[i] > 0) ? -33'sd1 : 33'sd0;
        end
`ifdef PIP_FIR_SAT_EN
        ovf_exp = 33'sd4294967295;
`else
        ovf_exp = -33'sd4093640706;
`endif

        reset = 1'b1;
        bus.x = '0;
        clear_model();
        #2;
        apply_reset(10, 33'sd12345);

        for (int i = 0; i < 40; i++) begin
            step(vecs[i].x, vecs[i].y, 1'b0, "impulse");
        end

        for (int i = 0; i < 32; i++) step(33'sd1000, '0, 1'b1, "dc_pos");
        check("dc_pos_settle", bus.y, 33'sd1000);
        for (int i = 0; i < 32; i++) step(-33'sd1000, '0, 1'b1, "dc_neg");
        check("dc_neg_settle", bus.y, -33'sd1000);
        for (int i = 0; i < NT; i++) step(33'sd0, '0, 1'b1, "flush");

        // Align full-scale samples with the coefficient signs so every tap adds.
        for (int t = 0; t < NT; t++) begin
            smp_t xv;
            xv = (coef[NT-1-t] > 0) ? 33'sd4294967295 :
                 (coef[NT-1-t] < 0) ? -33'sd4294967295 : 33'sd0;
            if (t == NT-1) step(xv, ovf_exp, 1'b0, "overflow");
            else           step(xv, '0, 1'b1, "ovf_ramp");
        end
        for (int i = 0; i < 8; i++) step(33'sd0, '0, 1'b1, "ovf_tail");

        for (int i = 0; i < 12; i++) step(33'sd1000, '0, 1'b1, "dc_pre_rst");
        apply_reset(1, 33'sd1000);
        for (int i = 0; i < 30; i++) step(33'sd1000, '0, 1'b1, "dc_post_rst");
        check("dc_post_rst_settle", bus.y, 33'sd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pip_fir_filter.md
Name: pip_fir_filter

Overview:
- Fully pipelined 16-tap direct-form FIR low-pass filter; one signed sample in and one signed sample out every clock, no handshake.
- Sits in the DSP datapath between a free-running sample source, such as a sine generator or ADC stream, and downstream logic.
- Fixed coefficients: Q1.15, symmetric, unity DC gain.

Parameters:
- DATA_W, 33: input/output sample width, two's complement.
- COEF_W, 16: coefficient width, signed Q1.15.
- NTAPS, 16: number of taps; must be a power of 2.
- COEF_FRAC, 15: right shift applied to the accumulator to form y.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- x  in  DATA_W  signed input sample, captured every rising edge.
- y  out  DATA_W  signed filtered output, registered.

Behaviour:
- Reset (reset=0), asynchronous: clears the delay line, product registers, adder-tree registers and y to 0 immediately.
- While in reset, x is ignored. Asserting reset mid-stream discards all in-flight samples.
- After release, y stays 0 until the first nonzero sample has propagated.
- Coefficients c0..c15: -128, -256, 0, 768, 2048, 3584, 4736, 5632, 5632, 4736, 3584, 2048, 768, 0, -256, -128. The sum is 32768.
- Math: y[n] = (sum over k of c_k * x[n-k]) >>> COEF_FRAC. This is an arithmetic shift (floor), with no rounding.
- Accumulation is full precision: ACC_W = DATA_W + COEF_W + log2(NTAPS) = 53 bits signed. No intermediate overflow is possible.
- Pipeline stages, each registered:
  - S0: x shifts into tap 0 of the delay line.
  - S1: NTAPS products.
  - S2..S5: binary adder tree, log2(NTAPS) levels.
  - S6: shift and output-format into y.
- LATENCY = 3 + log2(NTAPS) = 7. A sample presented before edge e first affects y after edge e+6; count e as edge 1, so y changes at the 7th edge.
- Output formatting with SAT_EN undefined: the low DATA_W bits of the shifted accumulator (two's-complement wrap).
- Every cycle is a valid sample; there is no stall or enable.
- x is sampled as signed. Negative values propagate with correct sign extension through all stages.

Optional Feature:
- Macro PIP_FIR_SAT_EN.
- Defined: the shifted accumulator is clamped to [-2^32, 2^32-1] before registering y; out-of-range results saturate.
- Undefined: plain truncation to DATA_W bits, i.e. wrap-around.
- Latency is identical in both builds.

Decomposition:
- Package pip_fir_pkg holds:
  - DATA_W, COEF_W, NTAPS, COEF_FRAC, ACC_W and LATENCY localparams;
  - typedefs sample_t (signed DATA_W), coef_t (signed COEF_W), acc_t (signed ACC_W);
  - constant array COEFS[NTAPS] of coef_t.
- Sub-module pip_fir_adder_tree: parameterised pipelined binary reduction of N acc_t inputs, one register per level, with async active-low reset.
- The top level holds the delay line, the multipliers and the output stage.

Test Plan:
- Reset: hold reset=0 for 10 cycles with x=12345 -> y=0 throughout. After release, y=0 for the first 6 edges.
- Impulse: x=32768 for one cycle, 0 otherwise -> starting at LATENCY, y reproduces -128, -256, 0, 768, …, -128 on 16 consecutive cycles, then 0.
- DC step: x=1000 held -> y ramps through the partial sums, then settles to exactly 1000 from cycle LATENCY+15 onward. With x=-1000, y settles to -1000.
- Sign/floor: impulse x=-1 -> y values are floor(-c_k/32768): -1 for positive c_k, 0 for zero and negative c_k.
- Overflow: drive x[n-k] = (2^32-1)*sign(c_k) so all taps align; the accumulator is 34304*(2^32-1).
  - With PIP_FIR_SAT_EN: y = 2^32-1.
  - Without: y = low 33 bits of (34304*(2^32-1))>>>15.
- Reset mid-stream: during the DC test, pulse reset low for 1 cycle -> y=0 immediately (asynchronous), then the ramp restarts from 0.
